// File: rtl/ff_jk_pkg.sv
// Shared JK encoding and next-state rule for the ff_jk flip-flop bank.
// Op is packed as {J,K} so the four standard JK actions map onto a 2-bit code.
package ff_jk_pkg;

  typedef logic [1:0] jk_op_t;

  localparam jk_op_t JK_HOLD = 2'b00;
  localparam jk_op_t JK_RST  = 2'b01;
  localparam jk_op_t JK_SET  = 2'b10;
  localparam jk_op_t JK_TGL  = 2'b11;

  function automatic logic next_q(input jk_op_t op, input logic q);
    logic nq;
    nq = q;
    case (op)
      JK_HOLD: nq = q;
      JK_RST:  nq = 1'b0;
      JK_SET:  nq = 1'b1;
      JK_TGL:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/ff_jk_bit.sv
// Single JK cell, one-edge latency, async active-low reset to RST_BIT.
// Optional clock enable CE when FF_JK_CE_EN is defined; CE=0 holds the bit.
module ff_jk_bit
  import ff_jk_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
`ifdef FF_JK_CE_EN
  input  logic CE,
`endif
  input  logic J,
  input  logic K,
  output logic Q
);

`ifdef FF_JK_CE_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= RST_BIT;
    end else if (CE) begin
      Q <= next_q({J, K}, Q);
    end
  end
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= RST_BIT;
    end else begin
      Q <= next_q({J, K}, Q);
    end
  end
`endif

endmodule

// File: rtl/ff_jk.sv
// Bank of WIDTH independent JK flip-flops, one-edge latency, Q1 is ~Q combinationally.
// Async active-low reset loads RESET_VAL; FF_JK_CE_EN adds a shared clock enable CE.
module ff_jk
  import ff_jk_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_N,
`ifdef FF_JK_CE_EN
  input  logic             CE,
`endif
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q1
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_jk_bit #(
      .RST_BIT (RESET_VAL[i])
    ) u_bit (
      .CLK   (CLK),
      .RST_N (RST_N),
`ifdef FF_JK_CE_EN
      .CE    (CE),
`endif
      .J     (J[i]),
      .K     (K[i]),
      .Q     (Q[i])
    );
  end

  // Derived from the register itself so Q and Q1 can never disagree.
  assign Q1 = ~Q;

endmodule

// File: tb/tb_ff_jk.sv
// Directed-vector bench for ff_jk (WIDTH=4), with a second instance using a nonzero reset value.
module tb_ff_jk;

  logic       CLK;
  logic       RST_N;
  logic       CE;
  logic [3:0] J;
  logic [3:0] K;
  logic [3:0] Q;
  logic [3:0] Q1;
  logic [3:0] q_b;
  logic [3:0] q1_b;

  int checks;
  int errors;

  ff_jk #(.WIDTH(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
`ifdef FF_JK_CE_EN
    .CE    (CE),
`endif
    .J     (J),
    .K     (K),
    .Q     (Q),
    .Q1    (Q1)
  );

  ff_jk #(.WIDTH(4), .RESET_VAL(4'b0101)) dut_b (
    .CLK   (CLK),
    .RST_N (RST_N),
`ifdef FF_JK_CE_EN
    .CE    (CE),
`endif
    .J     (J),
    .K     (K),
    .Q     (q_b),
    .Q1    (q1_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Move to the middle of the low phase, away from any edge.
  task automatic mid_cycle();
    @(negedge CLK);
    #2;
  endtask

  task automatic chk(input string name, input logic [3:0] q_exp);
    checks++;
    if (Q !== q_exp || Q1 !== ~q_exp) begin
      errors++;
      $display("FAIL %s: Q=%b Q1=%b required Q=%b Q1=%b", name, Q, Q1, q_exp, ~q_exp);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b1; CE = 1'b1; J = 4'b1111; K = 4'b0000;
    step();
    chk("preset_set", 4'b1111);
    mid_cycle();
    RST_N = 1'b0;
    #1;
    chk("reset_async", 4'b0000);
    checks++;
    if (q_b !== 4'b0101 || q1_b !== 4'b1010) begin
      errors++;
      $display("FAIL reset_val: q=%b q1=%b required q=0101 q1=1010", q_b, q1_b);
    end
    step();
    chk("reset_hold_edge1", 4'b0000);
    step();
    chk("reset_hold_edge2", 4'b0000);
    mid_cycle();
    J = 4'b0000; K = 4'b0000;
    RST_N = 1'b1;
    #1;
    chk("release_no_edge", 4'b0000);
  endtask

  task automatic test_hold();
    step();
    chk("hold_edge1", 4'b0000);
    step();
    chk("hold_edge2", 4'b0000);
    checks++;
    if (q_b !== 4'b0101) begin
      errors++;
      $display("FAIL hold_resetval: q=%b required 0101", q_b);
    end
    mid_cycle(); J = 4'b0001; K = 4'b0000;
    step();
    chk("set_bit0", 4'b0001);
    mid_cycle(); J = 4'b0000; K = 4'b0000;
    step();
    chk("hold_one", 4'b0001);
  endtask

  task automatic test_rst_set();
    mid_cycle(); J = 4'b0000; K = 4'b0001;
    step();
    chk("jk_reset", 4'b0000);
    mid_cycle(); J = 4'b0001; K = 4'b0000;
    step();
    chk("jk_set", 4'b0001);
  endtask

  task automatic test_toggle();
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'b0000; exp_seq[1] = 4'b0001;
    exp_seq[2] = 4'b0000; exp_seq[3] = 4'b0001;
    mid_cycle(); J = 4'b0001; K = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("toggle_%0d", i), exp_seq[i]);
    end
  endtask

  task automatic test_width();
    mid_cycle(); J = 4'b0011; K = 4'b1100;
    step();
    chk("width_load", 4'b0011);
    mid_cycle(); J = 4'b1010; K = 4'b0110;
    step();
    chk("width_mixed", 4'b1001);
    mid_cycle(); J = 4'b1111; K = 4'b1111;
    step();
    chk("width_toggle_all", 4'b0110);
    mid_cycle();
    RST_N = 1'b0;
    #1;
    chk("width_reset_async", 4'b0000);
    mid_cycle();
    RST_N = 1'b1; J = 4'b0000; K = 4'b0000;
  endtask

`ifdef FF_JK_CE_EN
  task automatic test_ce();
    mid_cycle(); J = 4'b0110; K = 4'b0000; CE = 1'b1;
    step();
    chk("ce_load", 4'b0110);
    mid_cycle(); J = 4'b1111; K = 4'b1111; CE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ce_off_%0d", i), 4'b0110);
    end
    mid_cycle(); CE = 1'b1;
    step();
    chk("ce_on_toggle", 4'b1001);
    mid_cycle(); CE = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("ce_off_reset", 4'b0000);
    mid_cycle();
    RST_N = 1'b1; CE = 1'b1; J = 4'b0000; K = 4'b0000;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    RST_N  = 1'b1;
    CE     = 1'b1;
    J      = 4'b0000;
    K      = 4'b0000;
    #2;
    test_reset();
    test_hold();
    test_rst_set();
    test_toggle();
    test_width();
`ifdef FF_JK_CE_EN
    test_ce();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
